// File: rtl/multi_cycle_controller_pkg.sv
// Shared encodings for the multi-cycle accumulator CPU controller.
// Holds the ALU operation codes driven on ALU_opc, the instruction opcode
// values found in IR[15:12], and the controller state type.
// No ports; imported by the interface, the controller and its decoder.
package cpu_defs;

  // ALU operation encodings
  localparam logic [2:0] ALU_PASS_B = 3'b000;
  localparam logic [2:0] ALU_PASS_A = 3'b001;
  localparam logic [2:0] ALU_ADD    = 3'b010;
  localparam logic [2:0] ALU_SUB    = 3'b011; // B - A, i.e. MDR - ACC in EXEC
  localparam logic [2:0] ALU_AND    = 3'b100;
  localparam logic [2:0] ALU_OR     = 3'b101;
  localparam logic [2:0] ALU_NOT    = 3'b110;

  // Instruction opcodes; every value above OP_NOT is treated as a NOP
  localparam logic [3:0] OP_LOAD  = 4'b0000;
  localparam logic [3:0] OP_STORE = 4'b0001;
  localparam logic [3:0] OP_JMP   = 4'b0010;
  localparam logic [3:0] OP_BZ    = 4'b0011;
  localparam logic [3:0] OP_ADD   = 4'b0100;
  localparam logic [3:0] OP_SUB   = 4'b0101;
  localparam logic [3:0] OP_AND   = 4'b0110;
  localparam logic [3:0] OP_OR    = 4'b0111;
  localparam logic [3:0] OP_NOT   = 4'b1000;

  // Controller states
  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_MEM_RD = 3'd2,
    ST_MEM_WR = 3'd3,
    ST_EXEC   = 3'd4
  } state_t;

  // True for instructions that fetch an operand from memory before EXEC
  function automatic logic needsMemRead(input logic [3:0] op);
    return (op == OP_LOAD) || (op == OP_ADD) || (op == OP_SUB) ||
           (op == OP_AND)  || (op == OP_OR);
  endfunction

endpackage

// File: rtl/multi_cycle_controller_if.sv
// Control bus between the multi-cycle controller and its datapath.
// Datapath -> controller: opcode (IR[15:12]), Zero (ALU zero flag),
//   mem_ready (memory access completes this cycle).
// Controller -> datapath: ALU_opc, ALU_srcA, ALU_srcB, IorD, MemRead,
//   MemWrite, IR_write, PC_write, ACC_write, PC_src, instr_done.
// The controller uses the master modport, the datapath the slave modport.
interface multi_cycle_controller_if;
  import cpu_defs::*;

  logic [3:0] opcode;
  logic       Zero;
  logic       mem_ready;

  logic [2:0] ALU_opc;
  logic       ALU_srcA;
  logic       ALU_srcB;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IR_write;
  logic       PC_write;
  logic       ACC_write;
  logic       PC_src;
  logic       instr_done;

  modport master (
    input  opcode, Zero, mem_ready,
    output ALU_opc, ALU_srcA, ALU_srcB, IorD, MemRead, MemWrite,
           IR_write, PC_write, ACC_write, PC_src, instr_done
  );

  modport slave (
    output opcode, Zero, mem_ready,
    input  ALU_opc, ALU_srcA, ALU_srcB, IorD, MemRead, MemWrite,
           IR_write, PC_write, ACC_write, PC_src, instr_done
  );

endinterface

// File: rtl/multi_cycle_controller_alu_op_decoder.sv
// Maps an instruction opcode to the ALU operation used in the EXEC state.
// Ports:
//   opcode_i  [3:0] instruction opcode (IR[15:12])
//   alu_opc_o [2:0] ALU operation for EXEC
// Opcodes that never reach EXEC return the idle pass-A encoding.
module alu_op_decoder
  import cpu_defs::*;
(
  input  logic [3:0] opcode_i,
  output logic [2:0] alu_opc_o
);

  always_comb begin
    alu_opc_o = ALU_PASS_A;
    case (opcode_i)
      OP_LOAD: alu_opc_o = ALU_PASS_B;
      OP_ADD:  alu_opc_o = ALU_ADD;
      OP_SUB:  alu_opc_o = ALU_SUB;
      OP_AND:  alu_opc_o = ALU_AND;
      OP_OR:   alu_opc_o = ALU_OR;
      OP_NOT:  alu_opc_o = ALU_NOT;
      default: alu_opc_o = ALU_PASS_A;
    endcase
  end

endmodule

// File: rtl/multi_cycle_controller.sv
// Multi-cycle control unit for a 16-bit accumulator CPU.
// Sequences FETCH -> DECODE -> (MEM_RD -> EXEC | MEM_WR | EXEC) -> FETCH
// and drives all datapath control lines combinationally from the state,
// the opcode, Zero and mem_ready.
// Ports:
//   clk  single rising-edge clock
//   rst  synchronous active-high reset
//   bus  control bus (master side), see multi_cycle_controller_if
module multi_cycle_controller
  import cpu_defs::*;
(
  input  logic                     clk,
  input  logic                     rst,
  multi_cycle_controller_if.master bus
);

  state_t     state_q, state_d;
  logic [2:0] execOpc;

  logic [2:0] aluOpc;
  logic       srcA, srcB, iorD, memRead, memWrite;
  logic       irWrite, pcWrite, accWrite, pcSrc, instrDone;

  alu_op_decoder u_alu_op_decoder (
    .opcode_i  (bus.opcode),
    .alu_opc_o (execOpc)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    aluOpc    = ALU_PASS_A;
    srcA      = 1'b0;
    srcB      = 1'b0;
    iorD      = 1'b0;
    memRead   = 1'b0;
    memWrite  = 1'b0;
    irWrite   = 1'b0;
    pcWrite   = 1'b0;
    accWrite  = 1'b0;
    pcSrc     = 1'b0;
    instrDone = 1'b0;

    case (state_q)
      // Read the instruction at PC and compute PC+1 in the same cycle;
      // IR and PC update only on the cycle memory completes.
      ST_FETCH: begin
        memRead = 1'b1;
        srcB    = 1'b1;
        aluOpc  = ALU_ADD;
        irWrite = bus.mem_ready;
        pcWrite = bus.mem_ready;
        if (bus.mem_ready) state_d = ST_DECODE;
      end

      // ACC passes through the ALU so Zero reflects ACC==0 for BZ.
      ST_DECODE: begin
        srcA    = 1'b1;
        aluOpc  = ALU_PASS_A;
        pcSrc   = 1'b1;
        pcWrite = (bus.opcode == OP_JMP) || ((bus.opcode == OP_BZ) && bus.Zero);
        if (needsMemRead(bus.opcode)) begin
          state_d = ST_MEM_RD;
        end else if (bus.opcode == OP_STORE) begin
          state_d = ST_MEM_WR;
        end else if (bus.opcode == OP_NOT) begin
          state_d = ST_EXEC;
        end else begin
          state_d   = ST_FETCH;
          instrDone = 1'b1;
        end
      end

      ST_MEM_RD: begin
        iorD    = 1'b1;
        memRead = 1'b1;
        if (bus.mem_ready) state_d = ST_EXEC;
      end

      ST_MEM_WR: begin
        iorD     = 1'b1;
        memWrite = 1'b1;
        if (bus.mem_ready) begin
          state_d   = ST_FETCH;
          instrDone = 1'b1;
        end
      end

      ST_EXEC: begin
        srcA      = 1'b1;
        srcB      = 1'b0;
        accWrite  = 1'b1;
        aluOpc    = execOpc;
        state_d   = ST_FETCH;
        instrDone = 1'b1;
      end

      default: state_d = ST_FETCH;
    endcase

    // Reset abandons whatever is in flight: no strobes or writes, and the
    // mux selects settle to their FETCH values.
    if (rst) begin
      state_d   = ST_FETCH;
      aluOpc    = ALU_ADD;
      srcA      = 1'b0;
      srcB      = 1'b1;
      iorD      = 1'b0;
      pcSrc     = 1'b0;
      memRead   = 1'b0;
      memWrite  = 1'b0;
      irWrite   = 1'b0;
      pcWrite   = 1'b0;
      accWrite  = 1'b0;
      instrDone = 1'b0;
    end
  end

  assign bus.ALU_opc    = aluOpc;
  assign bus.ALU_srcA   = srcA;
  assign bus.ALU_srcB   = srcB;
  assign bus.IorD       = iorD;
  assign bus.MemRead    = memRead;
  assign bus.MemWrite   = memWrite;
  assign bus.IR_write   = irWrite;
  assign bus.PC_write   = pcWrite;
  assign bus.ACC_write  = accWrite;
  assign bus.PC_src     = pcSrc;
  assign bus.instr_done = instrDone;

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Self-checking bench for multi_cycle_controller.
// Each instruction is expanded into its expected cycle-by-cycle control
// vectors from the instruction's class, the chosen memory wait counts and
// the Zero value in DECODE; inputs that do not matter in a cycle are random.
module tb_multi_cycle_controller;
  import cpu_defs::*;

  logic clk = 1'b0;
  logic rst;

  multi_cycle_controller_if bus();

  multi_cycle_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // {ALU_opc, srcA, srcB, IorD, MemRead, MemWrite, IR_write, PC_write,
  //  ACC_write, PC_src, instr_done}
  logic [12:0] obsVec;
  assign obsVec = {bus.ALU_opc, bus.ALU_srcA, bus.ALU_srcB, bus.IorD,
                   bus.MemRead, bus.MemWrite, bus.IR_write, bus.PC_write,
                   bus.ACC_write, bus.PC_src, bus.instr_done};

  function automatic logic [12:0] mk(input logic [2:0] opc, input bit a, input bit b,
                                     input bit iord, input bit mr, input bit mw,
                                     input bit irw, input bit pcw, input bit accw,
                                     input bit pcs, input bit done);
    return {opc, a, b, iord, mr, mw, irw, pcw, accw, pcs, done};
  endfunction

  // ALU operation each ACC-writing instruction needs in its final cycle
  function automatic logic [2:0] execOpcFor(input logic [3:0] op);
    case (op)
      4'd0:    return 3'b000;
      4'd4:    return 3'b010;
      4'd5:    return 3'b011;
      4'd6:    return 3'b100;
      4'd7:    return 3'b101;
      4'd8:    return 3'b110;
      default: return 3'b001;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [12:0] observed,
                             input logic [12:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %013b expected %013b", tag, observed, expected);
    end
  endtask

  // Drive one cycle's inputs just after the rising edge, check at the falling edge.
  task automatic stepCycle(input bit r, input bit m, input bit z,
                           input logic [12:0] expected, input string tag);
    rst           = r;
    bus.mem_ready = m;
    bus.Zero      = z;
    @(negedge clk);
    checkOutput(tag, obsVec, expected);
    @(posedge clk);
    #1;
  endtask

  function automatic bit rb();
    return bit'($urandom_range(0, 1));
  endfunction

  // Run one full instruction with fw FETCH waits, mw memory waits and Zero=z in DECODE.
  task automatic applyStimulus(input logic [3:0] op, input int fw, input int mw,
                               input bit z, input string tag);
    bit isBranch, isStore, isRead, isNot;
    isBranch   = (op == 4'd2) || (op == 4'd3) || (op >= 4'd9);
    isStore    = (op == 4'd1);
    isNot      = (op == 4'd8);
    isRead     = !isBranch && !isStore && !isNot;
    bus.opcode = op;
    for (int i = 0; i < fw; i++)
      stepCycle(0, 0, rb(), mk(3'b010,0,1,0,1,0,0,0,0,0,0), {tag, "/fetchwait"});
    stepCycle(0, 1, rb(), mk(3'b010,0,1,0,1,0,1,1,0,0,0), {tag, "/fetch"});
    stepCycle(0, rb(), z,
              mk(3'b001,1,0,0,0,0,0, (op == 4'd2) || ((op == 4'd3) && z), 0, 1, isBranch),
              {tag, "/decode"});
    if (isStore) begin
      for (int i = 0; i < mw; i++)
        stepCycle(0, 0, rb(), mk(3'b001,0,0,1,0,1,0,0,0,0,0), {tag, "/wrwait"});
      stepCycle(0, 1, rb(), mk(3'b001,0,0,1,0,1,0,0,0,0,1), {tag, "/write"});
    end
    if (isRead) begin
      for (int i = 0; i < mw; i++)
        stepCycle(0, 0, rb(), mk(3'b001,0,0,1,1,0,0,0,0,0,0), {tag, "/rdwait"});
      stepCycle(0, 1, rb(), mk(3'b001,0,0,1,1,0,0,0,0,0,0), {tag, "/read"});
    end
    if (isRead || isNot)
      stepCycle(0, rb(), rb(), mk(execOpcFor(op),1,0,0,0,0,0,0,1,0,1), {tag, "/exec"});
  endtask

  // Start a memory instruction, then pulse reset during its k-th wait cycle.
  task automatic resetDuringWait(input logic [3:0] op, input int k, input string tag);
    bus.opcode = op;
    stepCycle(0, 1, rb(), mk(3'b010,0,1,0,1,0,1,1,0,0,0), {tag, "/fetch"});
    stepCycle(0, rb(), 0, mk(3'b001,1,0,0,0,0,0,0,0,1,0), {tag, "/decode"});
    for (int i = 0; i < k; i++)
      stepCycle(0, 0, rb(), (op == 4'd1) ? mk(3'b001,0,0,1,0,1,0,0,0,0,0)
                                         : mk(3'b001,0,0,1,1,0,0,0,0,0,0), {tag, "/wait"});
    stepCycle(1, rb(), rb(), mk(3'b010,0,1,0,0,0,0,0,0,0,0), {tag, "/reset"});
  endtask

  initial begin
    rst           = 1'b1;
    bus.opcode    = 4'd0;
    bus.Zero      = 1'b0;
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      stepCycle(1, rb(), rb(), mk(3'b010,0,1,0,0,0,0,0,0,0,0), "reset");

    applyStimulus(4'd0, 0, 0, 0, "load");
    applyStimulus(4'd1, 0, 3, 0, "storeWait");
    applyStimulus(4'd3, 0, 0, 1, "bzTaken");
    applyStimulus(4'd3, 0, 0, 0, "bzNotTaken");
    applyStimulus(4'd2, 1, 0, 0, "jmp");
    applyStimulus(4'd5, 0, 0, 0, "sub");
    applyStimulus(4'd6, 0, 1, 0, "and");
    applyStimulus(4'd7, 2, 0, 1, "or");
    applyStimulus(4'd8, 0, 0, 0, "not");
    applyStimulus(4'hF, 0, 0, 1, "nop");

    resetDuringWait(4'd1, 1, "rstStore");
    applyStimulus(4'd4, 0, 0, 0, "addAfterRst");
    resetDuringWait(4'd0, 2, "rstLoad");
    applyStimulus(4'd1, 1, 1, 0, "storeAfterRst");

    for (int n = 0; n < 80; n++) begin
      applyStimulus(4'($urandom_range(0, 15)), $urandom_range(0, 2),
                    $urandom_range(0, 3), rb(), "rand");
      if ($urandom_range(0, 15) == 0)
        resetDuringWait(($urandom_range(0, 1) == 0) ? 4'd1 : 4'd7,
                        $urandom_range(0, 2), "randRst");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
